// File: rtl/dma_ctrl_pkg.sv
// Shared types and defaults for the DMA burst controller.
package dma_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } dma_state_e;

    localparam int DMA_BURST_LEN_DEF = 100;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   winner_idx
);

    localparam int SW = IW + 1;

    logic          found;
    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    // ptr is always < NREQ, so one conditional subtraction wraps the sum
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA channel sequencer: round-robin grant, fixed-length transfer burst,
// one-cycle completion pulse with optional early abort.
//
//   state | meaning
//   IDLE  | waiting for any req; latches winner into gnt
//   REQ   | one cycle of dma_req before data moves
//   XFER  | data_transfer high, xfer_cnt counting up
//   DONE  | one-cycle done (plus aborted if cut short), gnt still held
module dma_burst_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int BURST_LEN = DMA_BURST_LEN_DEF,
    localparam int CW       = $clog2(BURST_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic            dma_req,
    output logic            data_transfer,
    output logic            done,
    output logic            aborted,
    output logic [CW-1:0]   xfer_cnt
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NREQ - 1);

    dma_state_e      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dma_req_q, dma_req_d;
    logic            xfer_q, xfer_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;

    logic [NREQ-1:0] winner;
    logic [IW-1:0]   winner_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .ptr        (ptr_q),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = REQ;
                    gnt_d   = winner;
                    cnt_d   = '0;
                    ptr_d   = (winner_idx == IDX_MAX) ? '0 : winner_idx + 1'b1;
                end
            end
            REQ: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = XFER;
                end
            end
            XFER: begin
                // the cycle in which abort is seen still moved data
                cnt_d = cnt_q + 1'b1;
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        dma_req_d = (state_d == REQ) || (state_d == XFER);
        xfer_d    = (state_d == XFER);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            dma_req_q <= 1'b0;
            xfer_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            dma_req_q <= dma_req_d;
            xfer_q    <= xfer_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign gnt           = gnt_q;
    assign dma_req       = dma_req_q;
    assign data_transfer = xfer_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Directed bench for dma_burst_ctrl: reset, round-robin order, burst timing,
// abort corners and asynchronous reset mid-burst.
module tb_dma_burst_ctrl;

    localparam int NREQ = 4;
    localparam int BL   = 100;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       abort;
    logic [3:0] gnt;
    logic       dma_req;
    logic       data_transfer;
    logic       done;
    logic       aborted;
    logic [6:0] xfer_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_done_cyc = 0;

    dma_burst_ctrl #(.NREQ(NREQ), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .abort         (abort),
        .gnt           (gnt),
        .dma_req       (dma_req),
        .data_transfer (data_transfer),
        .done          (done),
        .aborted       (aborted),
        .xfer_cnt      (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // abort_at: 0 = no abort, -1 = abort in REQ, n>0 = abort on nth transfer cycle
    task automatic run_burst(input string tag, input logic [3:0] req_v,
                             input logic [3:0] exp_gnt, input int abort_at,
                             input bit drop_req, input bit chk_period);
        int   k, nx, exp_cnt, exp_k;
        bit   got_done;
        logic exp_ab;
        exp_ab  = (abort_at != 0);
        exp_cnt = (abort_at > 0) ? abort_at : ((abort_at < 0) ? 0 : BL);
        exp_k   = exp_cnt + 2;
        req = req_v;
        @(negedge clk);
        k = 1;
        chk($sformatf("%s.gnt", tag), 32'(gnt), 32'(exp_gnt));
        chk($sformatf("%s.req_dma", tag), 32'(dma_req), 32'd1);
        chk($sformatf("%s.req_xfer", tag), 32'(data_transfer), 32'd0);
        chk($sformatf("%s.req_cnt", tag), 32'(xfer_cnt), 32'd0);
        if (drop_req) req = 4'b0000;
        if (abort_at < 0) abort = 1'b1;
        nx = 0;
        got_done = 1'b0;
        while (!got_done && k < 300) begin
            @(negedge clk);
            k++;
            abort = 1'b0;
            if (done) begin
                got_done = 1'b1;
            end else if (data_transfer) begin
                nx++;
                if (nx == abort_at) abort = 1'b1;
            end
        end
        if (!got_done) begin
            chk($sformatf("%s.timeout", tag), 32'd0, 32'd1);
            return;
        end
        chk($sformatf("%s.done_lat", tag), 32'(k), 32'(exp_k));
        chk($sformatf("%s.aborted", tag), 32'(aborted), 32'(exp_ab));
        chk($sformatf("%s.cnt", tag), 32'(xfer_cnt), 32'(exp_cnt));
        chk($sformatf("%s.nxfer", tag), 32'(nx), 32'(exp_cnt));
        chk($sformatf("%s.done_xfer", tag), 32'(data_transfer), 32'd0);
        chk($sformatf("%s.done_dma", tag), 32'(dma_req), 32'd0);
        chk($sformatf("%s.done_gnt", tag), 32'(gnt), 32'(exp_gnt));
        if (chk_period)
            chk($sformatf("%s.period", tag), 32'(cyc - last_done_cyc), 32'(BL + 3));
        last_done_cyc = cyc;
        req = 4'b0000;
        @(negedge clk);
        chk($sformatf("%s.idle_done", tag), 32'(done), 32'd0);
        chk($sformatf("%s.idle_gnt", tag), 32'(gnt), 32'd0);
        chk($sformatf("%s.idle_ab", tag), 32'(aborted), 32'd0);
        chk($sformatf("%s.hold_cnt", tag), 32'(xfer_cnt), 32'(exp_cnt));
    endtask

    initial begin
        bit saw_done;
        reset_n = 1'b0;
        req     = 4'b1111;
        abort   = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.dma", 32'(dma_req), 32'd0);
        chk("rst.xfer", 32'(data_transfer), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.ab", 32'(aborted), 32'd0);
        chk("rst.cnt", 32'(xfer_cnt), 32'd0);
        reset_n = 1'b1;

        run_burst("first", 4'b1111, 4'b0001, 0, 1'b0, 1'b0);
        run_burst("rr1", 4'b1111, 4'b0010, 0, 1'b0, 1'b1);
        run_burst("rr2", 4'b1111, 4'b0100, 0, 1'b0, 1'b1);
        run_burst("rr3", 4'b1111, 4'b1000, 0, 1'b0, 1'b1);
        run_burst("rr4", 4'b1111, 4'b0001, 0, 1'b0, 1'b1);
        run_burst("single", 4'b0100, 4'b0100, 0, 1'b0, 1'b0);
        run_burst("ab40", 4'b1111, 4'b1000, 40, 1'b0, 1'b0);
        run_burst("ab100", 4'b1111, 4'b0001, 100, 1'b0, 1'b0);
        run_burst("abreq", 4'b1111, 4'b0010, -1, 1'b0, 1'b0);
        run_burst("drop", 4'b0100, 4'b0100, 0, 1'b1, 1'b0);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_ab.dma", 32'(dma_req), 32'd0);
        chk("idle_ab.done", 32'(done), 32'd0);
        chk("idle_ab.ab", 32'(aborted), 32'd0);

        req = 4'b0010;
        @(negedge clk);
        chk("mid.gnt", 32'(gnt), 32'b0010);
        req = 4'b0000;
        repeat (50) @(negedge clk);
        chk("mid.xfer", 32'(data_transfer), 32'd1);
        chk("mid.cnt", 32'(xfer_cnt), 32'd49);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst.gnt", 32'(gnt), 32'd0);
        chk("mid_rst.dma", 32'(dma_req), 32'd0);
        chk("mid_rst.xfer", 32'(data_transfer), 32'd0);
        chk("mid_rst.cnt", 32'(xfer_cnt), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || aborted) saw_done = 1'b1;
        end
        chk("mid_rst.no_done", 32'(saw_done), 32'd0);
        reset_n = 1'b1;
        run_burst("post_rst", 4'b1111, 4'b0001, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
